// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler and its round-robin arbiter.
package tick_sched_pkg;

    // Channel id width for a given channel count.
    function automatic int id_width(input int n_ch);
        return $clog2(n_ch);
    endfunction

    // The rr pointer indexes channels, so it is exactly one id wide.
    function automatic int rr_ptr_width(input int n_ch);
        return id_width(n_ch);
    endfunction

    // What a channel's counter does on the coming edge.
    typedef enum logic [1:0] {
        CH_PARKED = 2'd0,   // disabled or period 0: hold reload value
        CH_COUNT  = 2'd1,   // counting down
        CH_EXPIRE = 2'd2,   // cnt==0: reload and raise an expiry
        CH_CFG    = 2'd3    // period write to this channel
    } ch_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter
    import tick_sched_pkg::*;
#(
    parameter int  N_REQ    = 4,
    localparam int ID_WIDTH = rr_ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0]    req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [ID_WIDTH-1:0] gnt_id_o,
    output logic                any_o
);

    logic [ID_WIDTH-1:0] idx;
    logic                found;

    // Scan requests starting at the pointer, wrapping modulo N_REQ.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_o    = '0;
        gnt_id_o = '0;
        idx      = '0;
        found    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_WIDTH'((int'(ptr_i) + k) % N_REQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/tick_sched.sv
// Programmable periodic tick scheduler: N_CH period counters whose
// expiries are arbitrated round-robin onto one valid/ready tick stream.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int  N_CH      = 4,
    parameter int  CNT_WIDTH = 16,
    localparam int ID_WIDTH  = id_width(N_CH)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [N_CH-1:0]      en_i,
    input  logic                 cfg_we_i,
    input  logic [ID_WIDTH-1:0]  cfg_addr_i,
    input  logic [CNT_WIDTH-1:0] cfg_data_i,
    output logic                 tick_valid_o,
    output logic [ID_WIDTH-1:0]  tick_id_o,
    input  logic                 tick_ready_i,
    output logic [N_CH-1:0]      ovr_o,
    input  logic [N_CH-1:0]      ovr_clr_i
);

    localparam int PTR_W = rr_ptr_width(N_CH);

    logic [N_CH-1:0]     expire;
    logic [N_CH-1:0]     pend_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [N_CH-1:0]     gnt;
    logic [ID_WIDTH-1:0] gnt_id;
    logic                gnt_any;
    logic                free;
    logic [N_CH-1:0]     grant_vec;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_WIDTH-1:0] per_q;
        logic [CNT_WIDTH-1:0] cnt_q;
        ch_state_e            st;

        // Classify this channel's action; a config write overrides counting.
        always_comb begin
            st = CH_PARKED;
            if (cfg_we_i && int'(cfg_addr_i) == i)
                st = CH_CFG;
            else if (en_i[i] && per_q != '0)
                st = (cnt_q == '0) ? CH_EXPIRE : CH_COUNT;
        end

        assign expire[i] = (st == CH_EXPIRE);

        // Period register and down-counter.
        always_ff @(posedge clk_i) begin
            // NOTE: period/count are plain flops, not a RAM, so they reset; a parked channel must stay silent after reset.
            if (!rst_n_i) begin
                per_q <= '0;
                cnt_q <= '0;
            end else begin
                unique case (st)
                    CH_CFG: begin
                        per_q <= cfg_data_i;
                        cnt_q <= (cfg_data_i == '0) ? '0 : cfg_data_i - 1'b1;
                    end
                    CH_EXPIRE: cnt_q <= per_q - 1'b1;
                    CH_COUNT:  cnt_q <= cnt_q - 1'b1;
                    default:   cnt_q <= (per_q == '0) ? '0 : per_q - 1'b1;
                endcase
            end
        end
    end

    rr_arbiter #(.N_REQ(N_CH)) u_arb (
        .req_i    (pend_q),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .any_o    (gnt_any)
    );

    assign free      = !tick_valid_o || tick_ready_i;
    assign grant_vec = (free && gnt_any) ? gnt : '0;

    // Pending/overrun bookkeeping and the registered tick output.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pend_q       <= '0;
            ovr_o        <= '0;
            tick_valid_o <= 1'b0;
            tick_id_o    <= '0;
            rr_ptr_q     <= '0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            // A granted channel expiring in the same cycle stays pending without overrun.
            pend_q <= (pend_q & ~grant_vec) | expire;
            // Set wins over a same-cycle clear.
            ovr_o  <= (ovr_o & ~ovr_clr_i) | (expire & pend_q & ~grant_vec);
            if (free) begin
                tick_valid_o <= gnt_any;
                if (gnt_any) begin
                    tick_id_o <= gnt_id;
                    rr_ptr_q  <= (int'(gnt_id) == N_CH - 1) ? '0 : gnt_id + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_sched.sv
// Directed self-checking bench for tick_sched (N_CH=4, CNT_WIDTH=16).
module tb_tick_sched;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [3:0]  en_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_addr_i;
    logic [15:0] cfg_data_i;
    logic        tick_valid_o;
    logic [1:0]  tick_id_o;
    logic        tick_ready_i;
    logic [3:0]  ovr_o;
    logic [3:0]  ovr_clr_i;

    int checks = 0;
    int errors = 0;

    tick_sched #(.N_CH(4), .CNT_WIDTH(16)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_i         (en_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_data_i   (cfg_data_i),
        .tick_valid_o (tick_valid_o),
        .tick_id_o    (tick_id_o),
        .tick_ready_i (tick_ready_i),
        .ovr_o        (ovr_o),
        .ovr_clr_i    (ovr_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] p);
        cfg_we_i   = 1'b1;
        cfg_addr_i = a;
        cfg_data_i = p;
        cyc(1);
        cfg_we_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        cyc(1);
        rst_n_i = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n_i      = 1'b0;
        en_i         = '0;
        cfg_we_i     = 1'b0;
        cfg_addr_i   = '0;
        cfg_data_i   = '0;
        tick_ready_i = 1'b0;
        ovr_clr_i    = '0;

        // Reset held 3 cycles.
        cyc(3);
        check("rst_valid", tick_valid_o, 0);
        check("rst_id", tick_id_o, 0);
        check("rst_ovr", ovr_o, 0);
        rst_n_i = 1'b1;

        // Single channel, P=4: first tick 5 edges after the write, then every 4.
        en_i = 4'b0001;
        tick_ready_i = 1'b1;
        cfg_write(2'd0, 16'd4);
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            check("p4_quiet", tick_valid_o, 0);
        end
        cyc(1);
        check("p4_first_valid", tick_valid_o, 1);
        check("p4_first_id", tick_id_o, 0);
        cyc(1);
        check("p4_gap", tick_valid_o, 0);
        cyc(3);
        check("p4_second_valid", tick_valid_o, 1);
        check("p4_second_id", tick_id_o, 0);
        check("p4_ovr", ovr_o, 0);

        // P=1 on all channels: round-robin 0,1,2,3,0 and overruns everywhere.
        do_reset();
        en_i = 4'b0000;
        for (int c = 0; c < 4; c++) cfg_write(2'(c), 16'd1);
        cyc(1);
        en_i = 4'b1111;
        cyc(1);
        check("p1_first_edge_valid", tick_valid_o, 0);
        cyc(1);
        check("p1_id0", tick_id_o, 0);
        check("p1_valid", tick_valid_o, 1);
        check("p1_ovr_partial", ovr_o, 4'b1110);
        cyc(1);
        check("p1_id1", tick_id_o, 1);
        check("p1_ovr_all", ovr_o, 4'b1111);
        cyc(1);
        check("p1_id2", tick_id_o, 2);
        cyc(1);
        check("p1_id3", tick_id_o, 3);
        cyc(1);
        check("p1_id0_wrap", tick_id_o, 0);

        // Disable all and clear overruns: pending ticks still drain in order.
        en_i = 4'b0000;
        ovr_clr_i = 4'b1111;
        cyc(1);
        ovr_clr_i = 4'b0000;
        check("drain_ovr_clr", ovr_o, 0);
        check("drain_id1", tick_id_o, 1);
        cyc(1);
        check("drain_id2", tick_id_o, 2);
        cyc(1);
        check("drain_id3", tick_id_o, 3);
        cyc(1);
        check("drain_id0", tick_id_o, 0);
        check("drain_valid", tick_valid_o, 1);
        cyc(1);
        check("drain_empty", tick_valid_o, 0);

        // Backpressure on ch2, P=3.
        do_reset();
        tick_ready_i = 1'b0;
        en_i = 4'b0100;
        cfg_write(2'd2, 16'd3);
        cyc(4);
        check("bp_valid", tick_valid_o, 1);
        check("bp_id", tick_id_o, 2);
        cyc(4);
        check("bp_ovr_not_yet", ovr_o, 0);
        check("bp_hold_valid", tick_valid_o, 1);
        check("bp_hold_id", tick_id_o, 2);
        cyc(1);
        check("bp_ovr_set", ovr_o, 4'b0100);
        cyc(2);
        ovr_clr_i = 4'b0100;
        cyc(1);
        check("bp_set_beats_clr", ovr_o, 4'b0100);
        cyc(1);
        ovr_clr_i = 4'b0000;
        check("bp_clr", ovr_o, 0);
        check("bp_stall_valid", tick_valid_o, 1);
        check("bp_stall_id", tick_id_o, 2);
        tick_ready_i = 1'b1;
        cyc(1);
        check("bp_release_valid", tick_valid_o, 1);
        cyc(1);
        check("bp_release_gap", tick_valid_o, 0);
        cyc(1);
        check("bp_next_valid", tick_valid_o, 1);
        check("bp_next_id", tick_id_o, 2);

        // Reconfigure ch1 from P=8 to P=2 mid-count.
        do_reset();
        en_i = 4'b0010;
        cfg_write(2'd1, 16'd8);
        cyc(3);
        cfg_write(2'd1, 16'd2);
        cyc(1);
        check("rcfg_w1", tick_valid_o, 0);
        cyc(1);
        check("rcfg_w2", tick_valid_o, 0);
        cyc(1);
        check("rcfg_tick", tick_valid_o, 1);
        check("rcfg_id", tick_id_o, 1);
        cyc(1);
        check("rcfg_gap", tick_valid_o, 0);
        cyc(1);
        check("rcfg_tick2", tick_valid_o, 1);
        cyc(1);
        // ch1 expired on this edge: pending but not yet shown.
        check("dis_pend_quiet", tick_valid_o, 0);
        en_i = 4'b0000;
        cyc(1);
        check("dis_drain_valid", tick_valid_o, 1);
        check("dis_drain_id", tick_id_o, 1);
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            check("dis_silent", tick_valid_o, 0);
        end
        en_i = 4'b0010;
        cfg_write(2'd1, 16'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            check("park_silent", tick_valid_o, 0);
        end

        // ch3 P=1 alone: grant and expiry coincide every cycle.
        do_reset();
        en_i = 4'b1000;
        cfg_write(2'd3, 16'd1);
        cyc(1);
        check("same_first_quiet", tick_valid_o, 0);
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            check("same_valid", tick_valid_o, 1);
            check("same_id", tick_id_o, 3);
        end
        check("same_no_ovr", ovr_o, 0);

        // Stall, then reset mid-stall.
        tick_ready_i = 1'b0;
        cyc(1);
        check("stall_valid", tick_valid_o, 1);
        check("stall_ovr", ovr_o, 4'b1000);
        cyc(2);
        check("stall_id", tick_id_o, 3);
        rst_n_i = 1'b0;
        cyc(1);
        rst_n_i = 1'b1;
        check("midrst_valid", tick_valid_o, 0);
        check("midrst_id", tick_id_o, 0);
        check("midrst_ovr", ovr_o, 0);
        tick_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check("midrst_silent", tick_valid_o, 0);
        end
        cfg_write(2'd3, 16'd1);
        cyc(2);
        check("midrst_resume_valid", tick_valid_o, 1);
        check("midrst_resume_id", tick_id_o, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
